// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Brief    : Input/output valid-ready channels of the immediate generator.
// Revision : 1.0
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;

    // Producer of instructions and consumer of results
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Registered immediate generator with format code, PC-relative
//            target and a two-entry skid buffer. Define IMM_GEN_RVC_EN to
//            decode compressed (16-bit) encodings.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [2:0] c_fmt_none  = 3'd0;
    localparam logic [2:0] c_fmt_i     = 3'd1;
    localparam logic [2:0] c_fmt_s     = 3'd2;
    localparam logic [2:0] c_fmt_b     = 3'd3;
    localparam logic [2:0] c_fmt_u     = 3'd4;
    localparam logic [2:0] c_fmt_j     = 3'd5;
    localparam logic [2:0] c_fmt_shamt = 3'd6;

    logic [31:0]     w_inst;
    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic            w_is_auipc;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_accept;
    logic            w_out_free;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_fmt;
    logic [XLEN-1:0] r_out_target;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;
    logic [XLEN-1:0] r_skid_target;

    assign w_inst = bus.in_inst;

    // Every immediate fits in 32 bits (shamt and zero-extended forms are
    // non-negative), so one sign extension to XLEN covers all formats.
    always_comb begin
        w_imm32    = '0;
        w_fmt      = c_fmt_none;
        w_is_auipc = 1'b0;
        if (w_inst[1:0] == 2'b11) begin
            case (w_inst[6:0])
                c_op_load, c_op_jalr: begin
                    w_fmt   = c_fmt_i;
                    w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
                end
                c_op_imm: begin
                    if (w_inst[13:12] == 2'b01) begin
                        w_fmt = c_fmt_shamt;
                        if (XLEN == 64)
                            w_imm32 = {26'b0, w_inst[25:20]};
                        else
                            w_imm32 = {27'b0, w_inst[24:20]};
                    end else begin
                        w_fmt   = c_fmt_i;
                        w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
                    end
                end
                c_op_store: begin
                    w_fmt   = c_fmt_s;
                    w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
                end
                c_op_branch: begin
                    w_fmt   = c_fmt_b;
                    w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                               w_inst[30:25], w_inst[11:8], 1'b0};
                end
                c_op_lui, c_op_auipc: begin
                    w_fmt      = c_fmt_u;
                    w_is_auipc = (w_inst[6:0] == c_op_auipc);
                    w_imm32    = {w_inst[31:12], 12'b0};
                end
                c_op_jal: begin
                    w_fmt   = c_fmt_j;
                    w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                               w_inst[20], w_inst[30:21], 1'b0};
                end
                default: begin
                    w_fmt   = c_fmt_none;
                    w_imm32 = '0;
                end
            endcase
        end
`ifdef IMM_GEN_RVC_EN
        else begin
            // Compressed: selected by {funct3, quadrant}
            case ({w_inst[15:13], w_inst[1:0]})
                5'b000_01, 5'b010_01: begin
                    w_fmt   = c_fmt_i;
                    w_imm32 = {{26{w_inst[12]}}, w_inst[12], w_inst[6:2]};
                end
                5'b010_00: begin
                    w_fmt   = c_fmt_i;
                    w_imm32 = {25'b0, w_inst[5], w_inst[12:10], w_inst[6], 2'b0};
                end
                5'b110_00: begin
                    w_fmt   = c_fmt_s;
                    w_imm32 = {25'b0, w_inst[5], w_inst[12:10], w_inst[6], 2'b0};
                end
                5'b110_01, 5'b111_01: begin
                    w_fmt   = c_fmt_b;
                    w_imm32 = {{23{w_inst[12]}}, w_inst[12], w_inst[6:5], w_inst[2],
                               w_inst[11:10], w_inst[4:3], 1'b0};
                end
                5'b101_01, 5'b001_01: begin
                    // funct3 001 is C.ADDIW on RV64, not C.JAL
                    if (w_inst[15:13] == 3'b101 || XLEN == 32) begin
                        w_fmt   = c_fmt_j;
                        w_imm32 = {{20{w_inst[12]}}, w_inst[12], w_inst[8],
                                   w_inst[10:9], w_inst[6], w_inst[7], w_inst[2],
                                   w_inst[11], w_inst[5:3], 1'b0};
                    end
                end
                default: begin
                    w_fmt   = c_fmt_none;
                    w_imm32 = '0;
                end
            endcase
        end
`endif
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign w_target = (w_fmt == c_fmt_b || w_fmt == c_fmt_j || w_is_auipc)
                    ? bus.in_pc + w_imm : '0;

    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_out_free = ~r_out_valid | bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_imm     <= '0;
            r_out_fmt     <= c_fmt_none;
            r_out_target  <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_imm    <= '0;
            r_skid_fmt    <= c_fmt_none;
            r_skid_target <= '0;
        end else if (w_out_free) begin
            // Skid entry is older than anything arriving now; it goes first.
            // No accept can coincide with a full skid since in_ready is low.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_fmt    <= r_skid_fmt;
                r_out_target <= r_skid_target;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= w_imm;
                r_out_fmt    <= w_fmt;
                r_out_target <= w_target;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_imm    <= w_imm;
            r_skid_fmt    <= w_fmt;
            r_skid_target <= w_target;
        end
    end

    assign bus.in_ready   = ~r_skid_valid & ~rst;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_imm    = r_out_imm;
    assign bus.out_fmt    = r_out_fmt;
    assign bus.out_target = r_out_target;
endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Directed self-checking bench for imm_gen_pipe (XLEN 32 and 64).
// Revision : 1.0
// ============================================================================
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_gen_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic vec32(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] eimm, input logic [2:0] efmt,
                         input logic [31:0] etgt);
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(bus32.in_ready), 64'd1);
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = inst;
        bus32.in_pc     = pc;
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        chk({tag, " valid"},  64'(bus32.out_valid),  64'd1);
        chk({tag, " imm"},    64'(bus32.out_imm),    64'(eimm));
        chk({tag, " fmt"},    64'(bus32.out_fmt),    64'(efmt));
        chk({tag, " target"}, 64'(bus32.out_target), 64'(etgt));
    endtask

    task automatic vec64(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                         input logic [63:0] eimm, input logic [2:0] efmt,
                         input logic [63:0] etgt);
        @(negedge clk);
        bus64.in_valid = 1'b1;
        bus64.in_inst  = inst;
        bus64.in_pc    = pc;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        chk({tag, " valid"},  64'(bus64.out_valid), 64'd1);
        chk({tag, " imm"},    bus64.out_imm,        eimm);
        chk({tag, " fmt"},    64'(bus64.out_fmt),   64'(efmt));
        chk({tag, " target"}, bus64.out_target,     etgt);
    endtask

    initial begin
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.in_pc = '0; bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_inst = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(bus32.out_valid),  64'd0);
        chk("rst imm",       64'(bus32.out_imm),    64'd0);
        chk("rst fmt",       64'(bus32.out_fmt),    64'd0);
        chk("rst target",    64'(bus32.out_target), 64'd0);
        chk("rst in_ready",  64'(bus32.in_ready),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 64'(bus32.in_ready), 64'd1);

        // Back-to-back directed vectors, out_ready held high
        vec32("addi -1",   32'hFFF00093, 32'h0,        32'hFFFFFFFF, 3'd1, 32'h0);
        vec32("beq -4",    32'hFE000EE3, 32'h100,      32'hFFFFFFFC, 3'd3, 32'hFC);
        vec32("srai 3",    32'h4030D093, 32'h0,        32'h3,        3'd6, 32'h0);
        vec32("srai b25",  32'h4210D093, 32'h0,        32'h1,        3'd6, 32'h0);
        vec32("sw -8",     32'hFE112C23, 32'h40,       32'hFFFFFFF8, 3'd2, 32'h0);
        vec32("lui",       32'h800000B7, 32'h40,       32'h80000000, 3'd4, 32'h0);
        vec32("auipc",     32'h00001097, 32'h200,      32'h1000,     3'd4, 32'h1200);
        vec32("jal wrap",  32'h001000EF, 32'hFFFFFFF0, 32'h800,      3'd5, 32'h7F0);
        vec32("lw 4",      32'h00412083, 32'h0,        32'h4,        3'd1, 32'h0);
        vec32("jalr",      32'h800080E7, 32'h500,      32'hFFFFF800, 3'd1, 32'h0);
        vec32("add none",  32'h002081B3, 32'h500,      32'h0,        3'd0, 32'h0);
`ifdef IMM_GEN_RVC_EN
        vec32("c.li -1",   32'h000050FD, 32'h0,        32'hFFFFFFFF, 3'd1, 32'h0);
`else
        vec32("c.li off",  32'h000050FD, 32'h0,        32'h0,        3'd0, 32'h0);
`endif

        // Drain
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain valid", 64'(bus32.out_valid), 64'd0);

        // Stall: A held on output, B in skid, C waits
        @(negedge clk);
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = 32'hFFF00093;
        bus32.in_pc     = '0;
        @(posedge clk);
        #1;
        chk("stall A imm", 64'(bus32.out_imm), 64'hFFFFFFFF);
        @(negedge clk);
        bus32.in_inst = 32'h00412083;
        @(posedge clk);
        #1;
        chk("stall skid in_ready", 64'(bus32.in_ready), 64'd0);
        chk("stall A held",        64'(bus32.out_imm),  64'hFFFFFFFF);
        @(negedge clk);
        bus32.in_inst = 32'h4030D093;
        @(posedge clk);
        #1;
        chk("stall C waits", 64'(bus32.in_ready), 64'd0);
        chk("stall A fmt",   64'(bus32.out_fmt),  64'd1);
        @(negedge clk);
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release B imm",     64'(bus32.out_imm),   64'h4);
        chk("release B valid",   64'(bus32.out_valid), 64'd1);
        chk("release in_ready",  64'(bus32.in_ready),  64'd1);
        @(posedge clk);
        #1;
        chk("release C imm", 64'(bus32.out_imm), 64'h3);
        chk("release C fmt", 64'(bus32.out_fmt), 64'd6);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("release empty", 64'(bus32.out_valid), 64'd0);

        // Reset during a stall discards both entries
        @(negedge clk);
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = 32'hFE000EE3;
        bus32.in_pc     = 32'h100;
        @(posedge clk);
        @(negedge clk);
        bus32.in_inst = 32'h00412083;
        @(posedge clk);
        #1;
        chk("rst-stall full", 64'(bus32.in_ready), 64'd0);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst-stall in_ready", 64'(bus32.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst-stall valid",  64'(bus32.out_valid),  64'd0);
        chk("rst-stall imm",    64'(bus32.out_imm),    64'd0);
        chk("rst-stall target", 64'(bus32.out_target), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus32.out_ready = 1'b1;
        #1;
        chk("rst-stall ready back", 64'(bus32.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("rst-stall no ghost", 64'(bus32.out_valid), 64'd0);

        // XLEN = 64
        vec64("64 lui",   32'h800000B7, 64'h0,         64'hFFFFFFFF80000000, 3'd4, 64'h0);
        vec64("64 srai",  32'h4210D093, 64'h0,         64'd33,               3'd6, 64'h0);
        vec64("64 auipc", 32'h80000097, 64'h100000000, 64'hFFFFFFFF80000000, 3'd4, 64'h80000000);
        vec64("64 beq",   32'hFE000EE3, 64'h100,       64'hFFFFFFFFFFFFFFFC, 3'd3, 64'hFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction and its PC per handshake, extracts and sign-extends the immediate to XLEN bits, and classifies the encoding format. It also precomputes the PC-relative target. Results go out through a valid/ready interface with a two-entry skid buffer, so decode can stall without losing instructions and without a combinational ready path.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_inst` and `in_pc` are valid.
- `in_ready`  out  1: block can accept; transfer when `in_valid & in_ready`.
- `in_inst`  in  32: instruction word.
- `in_pc`  in  XLEN: PC of the instruction.
- `out_valid`  out  1: output fields are valid.
- `out_ready`  in  1: consumer accepts; transfer when `out_valid & out_ready`.
- `out_imm`  out  XLEN: generated immediate.
- `out_fmt`  out  3: format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt.
- `out_target`  out  XLEN: `pc + imm` for B, J and AUIPC; 0 otherwise.

## Operation
- Decode on `in_inst[6:0]`:
  - `0000011` load, `1100111` JALR: format I, immediate `sext(inst[31:20])`.
  - `0010011` OP-IMM:
    - funct3 001 or 101: format shamt, zero-extended. The shamt is `inst[24:20]` when XLEN=32 and `inst[25:20]` when XLEN=64.
    - Any other funct3: format I, immediate `sext(inst[31:20])`.
  - `0100011` store: format S, immediate `sext({inst[31:25],inst[11:7]})`.
  - `1100011` branch: format B, immediate `sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})`.
  - `0110111` LUI, `0010111` AUIPC: format U, immediate `sext({inst[31:12],12'b0})` to XLEN.
  - `1101111` JAL: format J, immediate `sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})`.
  - Anything else: format 0, immediate 0, target 0.
- `out_target` is computed modulo 2^XLEN; carry out is discarded.
- Skid buffer:
  - Main output register plus one skid entry.
  - `in_ready = ~skid_valid & ~rst`, driven from a register only.
  - Accepted data goes to the output register when it is empty or draining that cycle; otherwise it goes to the skid entry.
  - When the output drains and the skid entry is full, the skid entry moves into the output register.
- Order is always preserved; no entry is dropped or duplicated.

## Timing
- Latency is 1 cycle: data accepted at edge N is on the outputs after edge N when the output register is free.
- Throughput is 1 instruction per cycle while `out_ready` is held high.
- Simultaneous accept and drain with an empty skid entry: the new data goes straight to the output register, and the skid entry stays empty.
- With the output full and `out_ready` low: one more input is accepted into the skid entry, and `in_ready` falls on the next cycle.
- Output fields are stable while `out_valid & ~out_ready`.
- Reset:
  - `out_valid = 0`, `out_imm = 0`, `out_fmt = 0`, `out_target = 0`, skid entry empty, `in_ready = 0` while `rst` is high.
  - Reset in mid-stall discards both entries; `in_ready` returns to 1 in the first cycle after `rst` falls.

## Configuration
- `IMM_GEN_RVC_EN` defined: when `in_inst[1:0] != 2'b11`, the low 16 bits are decoded as a compressed instruction:
  - C.ADDI / C.LI (CI): format I, immediate `sext({inst[12],inst[6:2]})`.
  - C.LW / C.SW (CL/CS): format I or S respectively, immediate `zext({inst[5],inst[12:10],inst[6],2'b0})`.
  - C.BEQZ / C.BNEZ (CB): format B, immediate `sext({inst[12],inst[6:5],inst[2],inst[11:10],inst[4:3],1'b0})`.
  - C.J / C.JAL (CJ): format J, immediate `sext({inst[12],inst[8],inst[10:9],inst[6],inst[7],inst[2],inst[11],inst[5:3],1'b0})`. C.JAL applies only when XLEN=32.
  - Any other compressed encoding: format 0.
- `IMM_GEN_RVC_EN` undefined: every encoding with `inst[1:0] != 2'b11` gives format 0, immediate 0, target 0. No compressed decode logic is present.

## Test plan
- `0xFFF00093` (addi x1,x0,-1), `out_ready` = 1 → one cycle later: `out_imm = 0xFFFFFFFF`, `out_fmt = 1`, `out_target = 0`.
- `0xFE000EE3` (beq x0,x0,-4), PC `0x100` → `out_imm = 0xFFFFFFFC`, `out_fmt = 3`, `out_target = 0xFC`.
- `0x4030D093` (srai x1,x1,3) → `out_imm = 3`, `out_fmt = 6` (not `0x403`).
- XLEN=64, `0x800000B7` (lui x1,0x80000) → `out_imm = 0xFFFFFFFF80000000`, `out_fmt = 4`.
- Back-to-back inputs A, B, C with `out_ready` low for 3 cycles:
  - A is held on the output.
  - B is held in the skid entry.
  - `in_ready` falls and C waits.
  - With `out_ready` then high, A, B, C appear on consecutive cycles.
- `rst` pulsed during the stall above → `out_valid = 0` after the edge, A and B are lost, `in_ready = 1` in the cycle after `rst` falls.
- With `IMM_GEN_RVC_EN` defined, `0x50FD` (c.li x1,-1) → `out_imm = 0xFFFFFFFF`, `out_fmt = 1`. Without it → `out_imm = 0`, `out_fmt = 0`.
